execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the integer pipeline; sits directly after the decode stage.
//  Registers the decoded control bundle, resolves operands by forwarding and
//  evaluates the ALU op selected by ctl. Presents result, store data and
//  control to the memory stage. Detects load-use hazards and requests a stall.
// PARAMETERS
//  XLEN      32   datapath width
//  CTL_W     5    width of ALU control code
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, synchronous, active-high
//  stall            in   1      downstream (memory) busy: hold all output registers
//  imm              in   32     immediate from decode
//  ctl              in   5      ALU op code from decode
//  src_imm          in   1      1: opB = imm, 0: opB = rs2 value
//  src_pc           in   1      1: opA = pc_in, 0: opA = rs1 value
//  read_reg1        in   1      rs1 is a real source (forwarding/hazard qualifier)
//  read_reg2        in   1      rs2 is a real source
//  reg1_addr        in   5      rs1 index
//  reg2_addr        in   5      rs2 index
//  write_reg        in   5      rd index
//  reg_write        in   1      instruction writes rd
//  mem_read         in   1      load
//  mem_write        in   1      store
//  pc_in            in   32     pc of decoded instruction
//  rs1_data         in   32     regfile read data for reg1_addr (combinational)
//  rs2_data         in   32     regfile read data for reg2_addr (combinational)
//  wb_valid         in   1      writeback stage is writing wb_addr this cycle
//  wb_addr          in   5      writeback rd
//  wb_data          in   32     writeback value
//  alu_out          out  32     ALU result / memory address
//  store_data       out  32     forwarded rs2 value for stores
//  write_reg_out    out  5      rd
//  reg_write_out    out  1      rd write enable
//  mem_read_out     out  1      load
//  mem_write_out    out  1      store
//  load_use_stall   out  1      combinational: hold decode and fetch this cycle
// BEHAVIOUR
//  - Reset: all registered outputs 0; load_use_stall 0 (follows from registered state).
//  - Latency 1: inputs sampled at posedge, results visible the following cycle.
//  - stall=1: every output register holds; stall has priority over bubble/load.
//  - Forwarding per source (rs1, rs2), highest priority first:
//    1. EX/MEM: reg_write_out & ~mem_read_out & write_reg_out==addr & addr!=0 -> alu_out
//    2. WB:     wb_valid & wb_addr==addr & addr!=0 -> wb_data
//    3. otherwise rs*_data. Address 0 always yields 0, never forwarded.
//  - load_use_stall = ~stall & mem_read_out & reg_write_out & write_reg_out!=0 &
//    ((read_reg1 & reg1_addr==write_reg_out) | (read_reg2 & reg2_addr==write_reg_out)).
//  - When load_use_stall=1 (and stall=0): register a bubble: reg_write_out,
//    mem_read_out, mem_write_out <= 0, alu_out/store_data <= 0, write_reg_out <= 0.
//    Next cycle the load has advanced; same decode bundle re-sampled, now via WB fwd.
//  - opA = src_pc ? pc_in : fwdA;  opB = src_imm ? imm : fwdB;  store_data <= fwdB.
//  - ctl codes (32-bit, wrap-around on add/sub; shift amount = opB[4:0]):
//    0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT (signed, 0/1),
//    10 pass opB (LUI), 13 SLTU (unsigned, 0/1), 15 SRA (sign fill),
//    31 and any other code -> result 0.
//  - Control fields pass through unchanged when not bubbling.
//  - Simultaneous EX/MEM and WB match on same source: EX/MEM wins.
//  - rst asserted mid-stall or mid-hazard: outputs cleared next edge, hazard drops.
// TESTING
//  1. ADD imm: rs1_data=5, src_imm=1, imm=7, ctl=2 -> alu_out=12 one cycle later.
//  2. Back-to-back dep: addi x1=3 then add x2=x1+x1 (rs1_data stale 0) -> alu_out=6
//     via EX/MEM fwd; repeat with rd=x0 -> no fwd, alu_out=0+0.
//  3. Load-use: lw x5 then add using x5 -> load_use_stall=1 one cycle, bubble
//     (reg_write_out=0); next cycle wb_data=0x40 fwd -> alu_out=0x40+opB.
//  4. Shifts/compare: opA=0x80000000, opB=4: ctl 5 -> 0x08000000, ctl 15 ->
//     0xF8000000; opA=-1,opB=1: ctl 7 -> 1, ctl 13 -> 0.
//  5. stall=1 for 3 cycles with changing inputs -> all outputs frozen; release ->
//     result of inputs present on release edge.
//  6. AUIPC src_pc=1, pc_in=0x100, imm=0x1000, ctl=2 -> 0x1100; LUI ctl=10 -> 0x1000;
//     rst during stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage of the integer pipeline: operand forwarding, ALU evaluation and
// load-use hazard detection, with registered results toward the memory stage.
module execute_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CTL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [XLEN-1:0]  imm,
    input  logic [CTL_W-1:0] ctl,
    input  logic             src_imm,
    input  logic             src_pc,
    input  logic             read_reg1,
    input  logic             read_reg2,
    input  logic [4:0]       reg1_addr,
    input  logic [4:0]       reg2_addr,
    input  logic [4:0]       write_reg,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  alu_out,
    output logic [XLEN-1:0]  store_data,
    output logic [4:0]       write_reg_out,
    output logic             reg_write_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             load_use_stall
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0]        fwd_a;
    logic [XLEN-1:0]        fwd_b;
    logic [XLEN-1:0]        op_a;
    logic [XLEN-1:0]        op_b;
    logic signed [XLEN-1:0] op_a_s;
    logic signed [XLEN-1:0] op_b_s;
    logic [SHW-1:0]         shamt;
    logic [XLEN-1:0]        result;
    logic                   exmem_ok;

    // A load in EX/MEM has no result yet, so it is never a forwarding source.
    assign exmem_ok = reg_write_out & ~mem_read_out & (write_reg_out != 5'd0);

    // Operand forwarding: EX/MEM beats WB beats the register file; x0 is always 0.
    always_comb begin
        fwd_a = rs1_data;
        if (reg1_addr == 5'd0) begin
            fwd_a = '0;
        end else if (exmem_ok && (write_reg_out == reg1_addr)) begin
            fwd_a = alu_out;
        end else if (wb_valid && (wb_addr == reg1_addr)) begin
            fwd_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = rs2_data;
        if (reg2_addr == 5'd0) begin
            fwd_b = '0;
        end else if (exmem_ok && (write_reg_out == reg2_addr)) begin
            fwd_b = alu_out;
        end else if (wb_valid && (wb_addr == reg2_addr)) begin
            fwd_b = wb_data;
        end
    end

    assign op_a   = src_pc  ? pc_in : fwd_a;
    assign op_b   = src_imm ? imm   : fwd_b;
    assign op_a_s = op_a;
    assign op_b_s = op_b;
    assign shamt  = op_b[SHW-1:0];

    // ALU; unlisted codes yield 0.
    always_comb begin
        result = '0;
        case (ctl)
            CTL_W'(0):  result = op_a & op_b;
            CTL_W'(1):  result = op_a | op_b;
            CTL_W'(2):  result = op_a + op_b;
            CTL_W'(3):  result = op_a ^ op_b;
            CTL_W'(4):  result = op_a << shamt;
            CTL_W'(5):  result = op_a >> shamt;
            CTL_W'(6):  result = op_a - op_b;
            CTL_W'(7):  result = XLEN'(op_a_s < op_b_s);
            CTL_W'(10): result = op_b;
            CTL_W'(13): result = XLEN'(op_a < op_b);
            CTL_W'(15): result = op_a_s >>> shamt;
            default:    result = '0;
        endcase
    end

    assign load_use_stall = ~stall & mem_read_out & reg_write_out & (write_reg_out != 5'd0) &
                            ((read_reg1 & (reg1_addr == write_reg_out)) |
                             (read_reg2 & (reg2_addr == write_reg_out)));

    // Output registers: reset, hold on downstream stall, bubble on load-use, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out       <= '0;
            store_data    <= '0;
            write_reg_out <= '0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
        end else if (stall) begin
            alu_out       <= alu_out;
        end else if (load_use_stall) begin
            alu_out       <= '0;
            store_data    <= '0;
            write_reg_out <= '0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
        end else begin
            alu_out       <= result;
            store_data    <= fwd_b;
            write_reg_out <= write_reg;
            reg_write_out <= reg_write;
            mem_read_out  <= mem_read;
            mem_write_out <= mem_write;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a reference model pushes expected
// outputs into a scoreboard queue that is drained one cycle later.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, stall, src_imm, src_pc, read_reg1, read_reg2;
    logic        reg_write, mem_read, mem_write, wb_valid;
    logic [31:0] imm, pc_in, rs1_data, rs2_data, wb_data;
    logic [4:0]  ctl, reg1_addr, reg2_addr, write_reg, wb_addr;
    logic [31:0] alu_out, store_data;
    logic [4:0]  write_reg_out;
    logic        reg_write_out, mem_read_out, mem_write_out, load_use_stall;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
    } out_t;

    out_t m;
    out_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic lus_seen;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .imm(imm), .ctl(ctl),
        .src_imm(src_imm), .src_pc(src_pc), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .write_reg(write_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_out(alu_out), .store_data(store_data), .write_reg_out(write_reg_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .load_use_stall(load_use_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [4:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a + b;
            5'd3:  return a ^ b;
            5'd4:  return a << b[4:0];
            5'd5:  return a >> b[4:0];
            5'd6:  return a - b;
            5'd7:  return {31'd0, $signed(a) < $signed(b)};
            5'd10: return b;
            5'd13: return {31'd0, a < b};
            5'd15: return sa >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return 32'd0;
        if (m.rw && !m.mr && m.wr == addr) return m.alu;
        if (wb_valid && wb_addr == addr) return wb_data;
        return rf;
    endfunction

    // One clock: check hazard flag, predict next outputs, then compare after the edge.
    task automatic tick();
        out_t        nx, ex;
        logic        haz;
        logic [31:0] fa, fb, oa, ob;
        #1;
        haz = !stall && m.mr && m.rw && (m.wr != 5'd0) &&
              ((read_reg1 && reg1_addr == m.wr) || (read_reg2 && reg2_addr == m.wr));
        lus_seen = load_use_stall;
        check("lus", {31'd0, load_use_stall}, {31'd0, haz});
        fa = model_fwd(reg1_addr, rs1_data);
        fb = model_fwd(reg2_addr, rs2_data);
        oa = src_pc  ? pc_in : fa;
        ob = src_imm ? imm   : fb;
        if (rst)        nx = '0;
        else if (stall) nx = m;
        else if (haz)   nx = '0;
        else begin
            nx.alu = model_alu(ctl, oa, ob);
            nx.sd  = fb;
            nx.wr  = write_reg;
            nx.rw  = reg_write;
            nx.mr  = mem_read;
            nx.mw  = mem_write;
        end
        sb.push_back(nx);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        check("alu_out",    alu_out,                 ex.alu);
        check("store_data", store_data,              ex.sd);
        check("wr_out",     {27'd0, write_reg_out},  {27'd0, ex.wr});
        check("rw_out",     {31'd0, reg_write_out},  {31'd0, ex.rw});
        check("mr_out",     {31'd0, mem_read_out},   {31'd0, ex.mr});
        check("mw_out",     {31'd0, mem_write_out},  {31'd0, ex.mw});
        m = ex;
    endtask

    task automatic clear_in();
        stall = 0; imm = 0; ctl = 0; src_imm = 0; src_pc = 0; read_reg1 = 0; read_reg2 = 0;
        reg1_addr = 0; reg2_addr = 0; write_reg = 0; reg_write = 0; mem_read = 0;
        mem_write = 0; pc_in = 0; rs1_data = 0; rs2_data = 0; wb_valid = 0; wb_addr = 0;
        wb_data = 0;
    endtask

    initial begin
        logic [31:0] held;
        clear_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu", alu_out, 32'd0);
        check("rst_rw",  {31'd0, reg_write_out}, 32'd0);
        check("rst_lus", {31'd0, load_use_stall}, 32'd0);
        m = '0;
        tick();
        rst = 0;

        // ADD immediate
        rs1_data = 5; reg1_addr = 3; read_reg1 = 1; src_imm = 1; imm = 7; ctl = 2;
        write_reg = 4; reg_write = 1;
        tick();
        check("t1_add", alu_out, 32'd12);

        // back-to-back dependency through EX/MEM, then the same with rd=x0
        clear_in(); imm = 3; ctl = 2; src_imm = 1; write_reg = 1; reg_write = 1;
        tick();
        clear_in(); ctl = 2; reg1_addr = 1; reg2_addr = 1; read_reg1 = 1; read_reg2 = 1;
        write_reg = 2; reg_write = 1;
        tick();
        check("t2_fwd", alu_out, 32'd6);
        clear_in(); imm = 3; ctl = 2; src_imm = 1; write_reg = 0; reg_write = 1;
        tick();
        clear_in(); ctl = 2; read_reg1 = 1; read_reg2 = 1; rs1_data = 9; rs2_data = 9;
        write_reg = 2; reg_write = 1;
        tick();
        check("t2_x0", alu_out, 32'd0);

        // load-use: bubble, then WB forward of the load value
        clear_in(); ctl = 2; src_imm = 1; imm = 32'h20; write_reg = 5; reg_write = 1;
        mem_read = 1;
        tick();
        clear_in(); ctl = 2; read_reg1 = 1; reg1_addr = 5; src_imm = 1; imm = 4;
        write_reg = 6; reg_write = 1;
        tick();
        check("t3_stall", {31'd0, lus_seen}, 32'd1);
        check("t3_bubble", {31'd0, reg_write_out}, 32'd0);
        wb_valid = 1; wb_addr = 5; wb_data = 32'h40;
        tick();
        check("t3_wbfwd", alu_out, 32'h44);

        // EX/MEM beats WB on the same register (x6 = 0x44 now in EX/MEM)
        clear_in(); ctl = 2; read_reg1 = 1; reg1_addr = 6; src_imm = 1; imm = 1;
        wb_valid = 1; wb_addr = 6; wb_data = 32'hdead;
        tick();
        check("t_prio", alu_out, 32'h45);

        // shifts and compares
        clear_in(); src_pc = 1; src_imm = 1; pc_in = 32'h8000_0000; imm = 4; ctl = 5;
        tick();
        check("t4_srl", alu_out, 32'h0800_0000);
        ctl = 15;
        tick();
        check("t4_sra", alu_out, 32'hF800_0000);
        pc_in = 32'hFFFF_FFFF; imm = 1; ctl = 7;
        tick();
        check("t4_slt", alu_out, 32'd1);
        ctl = 13;
        tick();
        check("t4_sltu", alu_out, 32'd0);

        // downstream stall freezes outputs; release takes the inputs present then
        clear_in(); src_pc = 1; src_imm = 1; pc_in = 32'h10; imm = 32'h20; ctl = 2;
        write_reg = 9; reg_write = 1;
        tick();
        held = alu_out;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h100 * (i + 1); ctl = 5'(i); write_reg = 5'(i + 10);
            tick();
            check("t5_hold", alu_out, held);
        end
        stall = 0; pc_in = 32'h7; imm = 32'h3; ctl = 6;
        tick();
        check("t5_release", alu_out, 32'h4);

        // AUIPC / LUI
        clear_in(); src_pc = 1; src_imm = 1; pc_in = 32'h100; imm = 32'h1000; ctl = 2;
        tick();
        check("t6_auipc", alu_out, 32'h1100);
        ctl = 10;
        tick();
        check("t6_lui", alu_out, 32'h1000);

        // reset during a stall
        write_reg = 3; reg_write = 1; mem_write = 1;
        tick();
        stall = 1;
        tick();
        rst = 1;
        tick();
        check("t6_rst_stall", alu_out, 32'd0);
        rst = 0; stall = 0;

        // reset while a load-use hazard is pending
        clear_in(); ctl = 2; src_imm = 1; imm = 8; write_reg = 7; reg_write = 1; mem_read = 1;
        tick();
        clear_in(); read_reg2 = 1; reg2_addr = 7; ctl = 1; rst = 1;
        tick();
        check("t6_rst_haz", {31'd0, mem_read_out}, 32'd0);
        rst = 0;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            stall     = ($urandom_range(0, 7) == 0);
            imm       = $urandom();
            ctl       = 5'($urandom_range(0, 31));
            src_imm   = 1'($urandom_range(0, 1));
            src_pc    = 1'($urandom_range(0, 1));
            read_reg1 = 1'($urandom_range(0, 1));
            read_reg2 = 1'($urandom_range(0, 1));
            reg1_addr = 5'($urandom_range(0, 3));
            reg2_addr = 5'($urandom_range(0, 3));
            write_reg = 5'($urandom_range(0, 3));
            reg_write = 1'($urandom_range(0, 1));
            mem_read  = ($urandom_range(0, 3) == 0);
            mem_write = 1'($urandom_range(0, 1));
            pc_in     = $urandom();
            rs1_data  = $urandom();
            rs2_data  = $urandom();
            wb_valid  = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 3));
            wb_data   = $urandom();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
